// File: rtl/mux_scan_sel.sv
// Registered N:1 multiplexer with an active-low strobe. It runs in one of two modes:
// MANUAL, where i_sel picks the channel, and SCAN, which steps round-robin over the unmasked channels with a programmable dwell.
module mux_scan_sel #(
  parameter int NUM_CH  = 4,
  parameter int DATA_W  = 1,
  parameter int SEL_W   = $clog2(NUM_CH),
  parameter int DWELL_W = 8
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_g_n,
  input  logic                     i_mode,
  input  logic [SEL_W-1:0]         i_sel,
  input  logic [NUM_CH*DATA_W-1:0] i_data,
  input  logic [NUM_CH-1:0]        i_mask,
  input  logic [DWELL_W-1:0]       i_dwell,
  output logic [DATA_W-1:0]        o_y,
  output logic [SEL_W-1:0]         o_ch,
  output logic                     o_valid,
  output logic                     o_wrap
);

  typedef enum logic [1:0] {ST_IDLE, ST_MANUAL, ST_SCAN} state_e;

  state_e             state_q;
  logic [DATA_W-1:0]  y_q;
  logic [SEL_W-1:0]   ch_q;
  logic               valid_q;
  logic               wrap_q;
  logic               pend_q;
  logic [SEL_W-1:0]   p_q;
  logic [DWELL_W-1:0] cnt_q;

  logic [DATA_W-1:0]  ch [NUM_CH];
  logic [SEL_W-1:0]   nxt_p_d;
  logic [DWELL_W-1:0] cnt_eff;
  logic               adv;
  logic               any_mask;
  logic               sel_ok;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_unpack
    assign ch[g] = i_data[g*DATA_W +: DATA_W];
  end

  // Next unmasked channel strictly after p, wrapping; lands back on p if it is the only one.
  always_comb begin
    int  idx;
    logic found;
    nxt_p_d = p_q;
    found   = 1'b0;
    idx     = 0;
    for (int k = 1; k <= NUM_CH; k++) begin
      idx = (int'(p_q) + k) % NUM_CH;
      if (!found && i_mask[idx[SEL_W-1:0]]) begin
        nxt_p_d = idx[SEL_W-1:0];
        found   = 1'b1;
      end
    end
  end

  // A fresh entry into SCAN counts as the first dwell cycle of the current channel.
  assign cnt_eff  = (state_q == ST_SCAN) ? cnt_q : '0;
  assign adv      = (cnt_eff == i_dwell) || !i_mask[p_q];
  assign any_mask = |i_mask;
  assign sel_ok   = int'(i_sel) < NUM_CH;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      y_q     <= '0;
      ch_q    <= '0;
      valid_q <= 1'b0;
      wrap_q  <= 1'b0;
      pend_q  <= 1'b0;
      p_q     <= '0;
      cnt_q   <= '0;
    end else if (i_g_n) begin
      state_q <= ST_IDLE;
      y_q     <= '0;
      valid_q <= 1'b0;
      wrap_q  <= 1'b0;
      pend_q  <= 1'b0;
    end else if (!i_mode) begin
      state_q <= ST_MANUAL;
      ch_q    <= i_sel;
      cnt_q   <= '0;
      wrap_q  <= 1'b0;
      pend_q  <= 1'b0;
      y_q     <= sel_ok ? ch[i_sel] : '0;
      valid_q <= sel_ok;
    end else begin
      state_q <= ST_SCAN;
      ch_q    <= p_q;
      if (!any_mask) begin
        y_q     <= '0;
        valid_q <= 1'b0;
        wrap_q  <= 1'b0;
        pend_q  <= 1'b0;
        cnt_q   <= cnt_eff;
      end else begin
        y_q     <= ch[p_q];
        valid_q <= i_mask[p_q];
        // Wrap is flagged at the advance and shown alongside the first sample of the new channel.
        wrap_q  <= pend_q;
        if (adv) begin
          p_q    <= nxt_p_d;
          cnt_q  <= '0;
          pend_q <= (nxt_p_d <= p_q);
        end else begin
          cnt_q  <= cnt_eff + 1'b1;
          pend_q <= 1'b0;
        end
      end
    end
  end

  assign o_y     = y_q;
  assign o_ch    = ch_q;
  assign o_valid = valid_q;
  assign o_wrap  = wrap_q;

endmodule

// File: tb/tb_mux_scan_sel.sv
// Randomised and directed bench for mux_scan_sel, scored against a behavioural model of the channel scan.
module tb_mux_scan_sel;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       g_n = 1'b1;
  logic       mode = 1'b0;
  logic [1:0] sel = '0;
  logic [3:0] data = '0;
  logic [3:0] mask = '0;
  logic [7:0] dwell = '0;
  logic       y;
  logic [1:0] och;
  logic       valid;
  logic       wrap;

  int n_chk = 0;
  int n_fail = 0;

  // Model state
  int   m_p, m_cnt, m_ch;
  bit   m_scan, m_pend;
  logic m_y, m_valid, m_wrap;

  mux_scan_sel dut (
    .i_clk(clk), .i_rst(rst), .i_g_n(g_n), .i_mode(mode), .i_sel(sel),
    .i_data(data), .i_mask(mask), .i_dwell(dwell),
    .o_y(y), .o_ch(och), .o_valid(valid), .o_wrap(wrap)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog timeout checks=%0d", n_chk);
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_p = 0; m_cnt = 0; m_ch = 0; m_scan = 0; m_pend = 0;
    m_y = 0; m_valid = 0; m_wrap = 0;
  endtask

  task automatic model_step();
    int c, np, j;
    bit found;
    if (g_n) begin
      m_y = 0; m_valid = 0; m_wrap = 0; m_pend = 0; m_scan = 0;
    end else if (!mode) begin
      m_ch = int'(sel); m_cnt = 0; m_wrap = 0; m_pend = 0; m_scan = 0;
      m_y = data[sel]; m_valid = 1;
    end else begin
      c = m_scan ? m_cnt : 0;
      m_ch = m_p;
      m_scan = 1;
      if (mask == 4'b0000) begin
        m_y = 0; m_valid = 0; m_wrap = 0; m_pend = 0; m_cnt = c;
      end else begin
        m_y = data[m_p[1:0]];
        m_valid = mask[m_p[1:0]];
        m_wrap = m_pend;
        if (c == int'(dwell) || !mask[m_p[1:0]]) begin
          np = m_p; found = 0;
          for (int k = 1; k <= 4; k++) begin
            j = (m_p + k) % 4;
            if (!found && mask[j[1:0]]) begin np = j; found = 1; end
          end
          m_pend = (np <= m_p);
          m_p = np;
          m_cnt = 0;
        end else begin
          m_cnt = (c + 1) % 256;
          m_pend = 0;
        end
      end
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    chk("y", int'(y), int'(m_y));
    chk("ch", int'(och), m_ch);
    chk("valid", int'(valid), int'(m_valid));
    chk("wrap", int'(wrap), int'(m_wrap));
  endtask

  // Called just after an edge: pulses reset inside the cycle and checks the immediate clear.
  task automatic mid_reset();
    #3;
    rst = 1'b1;
    #1;
    chk("rst_y", int'(y), 0);
    chk("rst_ch", int'(och), 0);
    chk("rst_valid", int'(valid), 0);
    chk("rst_wrap", int'(wrap), 0);
    model_reset();
    #1;
    rst = 1'b0;
  endtask

  int exp3 [13] = '{0, 0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 3, 0};
  int exp4 [6]  = '{0, 1, 3, 1, 3, 1};
  int frozen, n, seen;
  bit hit;

  initial begin
    model_reset();
    rst = 1'b1;
    #12;
    chk("por_valid", int'(valid), 0);
    chk("por_ch", int'(och), 0);
    rst = 1'b0;

    // Manual selection, then reset with a valid output pending
    g_n = 0; mode = 0; data = 4'b0100; sel = 2;
    cyc();
    chk("man_y", int'(y), 1);
    chk("man_ch", int'(och), 2);
    chk("man_valid", int'(valid), 1);
    mid_reset();
    sel = 2;
    cyc();
    sel = 1;
    cyc();
    chk("man_y_sel1", int'(y), 0);
    g_n = 1;
    cyc();
    chk("gate_y", int'(y), 0);
    chk("gate_valid", int'(valid), 0);

    // Full-mask scan with dwell 2
    mid_reset();
    g_n = 0; mode = 1; mask = 4'b1111; dwell = 2;
    for (int i = 0; i < 13; i++) begin
      cyc();
      chk("scan3_ch", int'(och), exp3[i]);
      chk("scan3_wrap", int'(wrap), (i == 12) ? 1 : 0);
    end

    // Sparse mask, dwell 0
    mid_reset();
    mask = 4'b1010; dwell = 0;
    for (int i = 0; i < 6; i++) begin
      cyc();
      chk("scan4_ch", int'(och), exp4[i]);
      chk("scan4_valid", int'(valid), (i == 0) ? 0 : 1);
      chk("scan4_wrap", int'(wrap), (i == 3 || i == 5) ? 1 : 0);
    end

    // All masked, then a single channel enabled
    mask = 4'b0000;
    cyc();
    frozen = int'(och);
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("mask0_valid", int'(valid), 0);
      chk("mask0_wrap", int'(wrap), 0);
      chk("mask0_ch", int'(och), frozen);
    end
    mask = 4'b0100;
    hit = 0;
    for (int i = 0; i < 6 && !hit; i++) begin
      cyc();
      if (och == 2'd2) hit = 1;
    end
    chk("mask1_reach2", int'(hit), 1);

    // Strobe gap during a dwell on ch1
    mid_reset();
    mask = 4'b1111; dwell = 2;
    for (int i = 0; i < 4; i++) cyc();
    chk("gap_pre_ch", int'(och), 1);
    g_n = 1;
    for (int i = 0; i < 3; i++) cyc();
    g_n = 0;
    n = 0; seen = 0;
    for (int i = 0; i < 8 && seen == 0; i++) begin
      cyc();
      if (och == 2'd1 && valid) n++;
      else seen = int'(och) + 1;
    end
    chk("gap_ch1_cycles", n, 3);
    chk("gap_next_ch", seen, 3);

    // Random traffic
    for (int i = 0; i < 4000; i++) begin
      data = 4'($urandom);
      sel  = 2'($urandom);
      if ($urandom_range(0, 15) == 0) mask = 4'($urandom);
      if ($urandom_range(0, 31) == 0) dwell = 8'($urandom_range(0, 4));
      if ($urandom_range(0, 19) == 0) mode = ~mode;
      if ($urandom_range(0, 15) == 0) g_n = ~g_n;
      if ($urandom_range(0, 7) == 0 && g_n) g_n = 0;
      cyc();
      if ($urandom_range(0, 249) == 0) mid_reset();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
